// File: rtl/config_shift_if.sv
// Configuration link bundle: the 3-wire serial side from the sequencer and
// the committed parallel word plus status going to the render core.
interface config_shift_if #(
  parameter int WIDTH = 33
);
  logic             cfg_enable;
  logic             cfg_data;
  logic             cfg_sclk;
  logic [WIDTH-1:0] config_word;
  logic             config_valid;
  logic             busy;
  logic             frame_error;
  logic [5:0]       bit_count;

  modport master (
    output cfg_enable, cfg_data, cfg_sclk,
    input  config_word, config_valid, busy, frame_error, bit_count
  );

  modport slave (
    input  cfg_enable, cfg_data, cfg_sclk,
    output config_word, config_valid, busy, frame_error, bit_count
  );
endinterface

// File: rtl/config_shift_receiver.sv
// Receives an LSB-first serial configuration frame on a slow shift clock and
// commits it atomically to a parallel register, flagging short and overrun frames.
module config_shift_receiver #(
  parameter int               WIDTH       = 33,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic           clk,
  input logic           reset,
  config_shift_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  localparam logic [5:0] LAST = 6'(WIDTH - 1);

  logic [SYNC_STAGES-1:0] en_sync, d_sync, sclk_sync, fill;
  logic                   en_p, sclk_p;
  logic                   en_s, d_s, sclk_s;
  logic                   sclk_rise, en_rise, en_fall;
  logic [WIDTH-1:0]       shreg, shreg_next;
  state_t                 state;

  assign en_s       = en_sync[SYNC_STAGES-1];
  assign d_s        = d_sync[SYNC_STAGES-1];
  assign sclk_s     = sclk_sync[SYNC_STAGES-1];
  assign sclk_rise  = sclk_s & ~sclk_p;
  assign en_rise    = en_s & ~en_p;
  assign en_fall    = ~en_s & en_p;
  assign shreg_next = {d_s, shreg[WIDTH-1:1]};

  // Synchronizer flops reset to 0, so the delayed copies are held high until
  // the chain carries real samples; a line held high through reset must not
  // look like a fresh rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_sync   <= '0;
      d_sync    <= '0;
      sclk_sync <= '0;
      fill      <= '0;
      en_p      <= 1'b1;
      sclk_p    <= 1'b1;
    end else begin
      en_sync   <= {en_sync[SYNC_STAGES-2:0], bus.cfg_enable};
      d_sync    <= {d_sync[SYNC_STAGES-2:0], bus.cfg_data};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.cfg_sclk};
      fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
      en_p      <= fill[SYNC_STAGES-1] ? en_s : 1'b1;
      sclk_p    <= fill[SYNC_STAGES-1] ? sclk_s : 1'b1;
    end
  end

  // Shift register holds data only; every committed frame overwrites it fully.
  always_ff @(posedge clk) begin
    if (state == RECV && !en_fall && sclk_rise) begin
      shreg <= shreg_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      bus.config_word  <= RESET_VALUE;
      bus.config_valid <= 1'b0;
      bus.busy         <= 1'b0;
      bus.frame_error  <= 1'b0;
      bus.bit_count    <= '0;
    end else begin
      bus.config_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (en_rise) begin
            state           <= RECV;
            bus.busy        <= 1'b1;
            bus.bit_count   <= '0;
            bus.frame_error <= 1'b0;
          end
        end
        RECV: begin
          if (en_fall) begin
            state           <= IDLE;
            bus.busy        <= 1'b0;
            bus.frame_error <= 1'b1;
          end else if (sclk_rise) begin
            bus.bit_count <= bus.bit_count + 6'd1;
            if (bus.bit_count == LAST) begin
              state            <= DONE;
              bus.busy         <= 1'b0;
              bus.config_word  <= shreg_next;
              bus.config_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (en_fall) begin
            state <= IDLE;
          end else if (sclk_rise) begin
            bus.frame_error <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_shift_receiver.sv
// Directed bench for config_shift_receiver: nominal, short, overrun, reset
// mid-frame, back-to-back and coincident-edge frames.
module tb_config_shift_receiver;

  localparam int WIDTH = 33;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   vcount = 0;
  int   v0;

  config_shift_if #(.WIDTH(WIDTH)) bus ();

  config_shift_receiver #(
    .WIDTH(WIDTH),
    .SYNC_STAGES(2),
    .RESET_VALUE(33'h0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.config_valid === 1'b1) vcount <= vcount + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic d);
    bus.cfg_data = d;
    tick(1);
    bus.cfg_sclk = 1'b1;
    tick(1);
    bus.cfg_sclk = 1'b0;
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[i]);
  endtask

  task automatic wait_commit(input logic [WIDTH-1:0] exp);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick(1);
      if (bus.config_valid === 1'b1) seen = 1'b1;
    end
    check("commit_seen", 64'(seen), 64'd1);
    check("commit_config", 64'(bus.config_word), 64'(exp));
  endtask

  initial begin
    reset          = 1'b1;
    bus.cfg_enable = 1'b0;
    bus.cfg_data   = 1'b0;
    bus.cfg_sclk   = 1'b0;
    tick(3);
    check("rst_config", 64'(bus.config_word), 64'h0);
    check("rst_valid", 64'(bus.config_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_ferr", 64'(bus.frame_error), 64'd0);
    check("rst_count", 64'(bus.bit_count), 64'd0);
    reset = 1'b0;
    tick(4);

    // Nominal frame
    bus.cfg_enable = 1'b1;
    tick(4);
    check("t1_busy", 64'(bus.busy), 64'd1);
    v0 = vcount;
    send_frame(33'h03C000000, 33);
    wait_commit(33'h03C000000);
    check("t1_busy_drop", 64'(bus.busy), 64'd0);
    check("t1_count", 64'(bus.bit_count), 64'd33);
    tick(3);
    check("t1_ferr", 64'(bus.frame_error), 64'd0);
    check("t1_pulses", 64'(vcount - v0), 64'd1);

    // Short frame
    bus.cfg_enable = 1'b0;
    tick(4);
    bus.cfg_enable = 1'b1;
    tick(4);
    v0 = vcount;
    send_frame(33'h1FFFFFFFF, 20);
    tick(4);
    check("t2_count", 64'(bus.bit_count), 64'd20);
    bus.cfg_enable = 1'b0;
    tick(5);
    check("t2_config", 64'(bus.config_word), 64'h03C000000);
    check("t2_ferr", 64'(bus.frame_error), 64'd1);
    check("t2_busy", 64'(bus.busy), 64'd0);
    check("t2_pulses", 64'(vcount - v0), 64'd0);

    // Overrun
    bus.cfg_enable = 1'b1;
    tick(4);
    check("t3_ferr_clear", 64'(bus.frame_error), 64'd0);
    v0 = vcount;
    send_frame(33'h155555555, 33);
    tick(5);
    check("t3_config", 64'(bus.config_word), 64'h155555555);
    check("t3_ferr_pre", 64'(bus.frame_error), 64'd0);
    send_frame(33'h7, 3);
    tick(5);
    check("t3_ferr", 64'(bus.frame_error), 64'd1);
    check("t3_config_kept", 64'(bus.config_word), 64'h155555555);
    check("t3_count", 64'(bus.bit_count), 64'd33);
    check("t3_pulses", 64'(vcount - v0), 64'd1);
    bus.cfg_enable = 1'b0;
    tick(4);

    // Reset mid-frame
    bus.cfg_enable = 1'b1;
    tick(4);
    v0 = vcount;
    send_frame(33'h3FF, 10);
    tick(4);
    check("t4_count_pre", 64'(bus.bit_count), 64'd10);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    check("t4_config", 64'(bus.config_word), 64'h0);
    check("t4_count", 64'(bus.bit_count), 64'd0);
    check("t4_busy", 64'(bus.busy), 64'd0);
    tick(5);
    check("t4_no_start", 64'(bus.busy), 64'd0);
    send_frame(33'h1F, 5);
    tick(5);
    check("t4_idle_busy", 64'(bus.busy), 64'd0);
    check("t4_idle_count", 64'(bus.bit_count), 64'd0);
    check("t4_pulses", 64'(vcount - v0), 64'd0);
    bus.cfg_enable = 1'b0;
    tick(4);
    bus.cfg_enable = 1'b1;
    tick(4);
    check("t4_restart", 64'(bus.busy), 64'd1);

    // Back-to-back frames with a one-cycle enable gap
    v0 = vcount;
    send_frame(33'h0AAAAAAAA, 33);
    tick(5);
    check("t5_first", 64'(bus.config_word), 64'h0AAAAAAAA);
    bus.cfg_enable = 1'b0;
    tick(1);
    bus.cfg_enable = 1'b1;
    tick(4);
    check("t5_busy", 64'(bus.busy), 64'd1);
    send_frame(33'h0FFFF0000, 33);
    tick(5);
    check("t5_config", 64'(bus.config_word), 64'h0FFFF0000);
    check("t5_pulses", 64'(vcount - v0), 64'd2);
    check("t5_ferr", 64'(bus.frame_error), 64'd0);
    bus.cfg_enable = 1'b0;
    tick(4);

    // Coincident enable and sclk rise
    v0 = vcount;
    bus.cfg_data   = 1'b1;
    bus.cfg_enable = 1'b1;
    bus.cfg_sclk   = 1'b1;
    tick(1);
    bus.cfg_sclk = 1'b0;
    tick(1);
    send_frame(33'h123456789, 33);
    tick(5);
    check("t6_config", 64'(bus.config_word), 64'h123456789);
    check("t6_pulses", 64'(vcount - v0), 64'd1);
    check("t6_ferr", 64'(bus.frame_error), 64'd0);
    check("t6_count", 64'(bus.bit_count), 64'd33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/config_shift_receiver.md
Name: config_shift_receiver

Overview:
- Receiving end of the 3-wire configuration link (enable, serial data, shift clock) that the board-level sequencer drives into the Mandelbrot core.
- Samples the slow, software-timed shift clock with the system clock and assembles an LSB-first frame of WIDTH bits.
- Commits a complete frame atomically to a parallel configuration register, which feeds the render core.
- Detects short frames and overrun bits, and reports both.

Parameters:
- WIDTH, 33, number of configuration bits per frame.
- SYNC_STAGES, 2, synchronizer flops per serial input (≥2).
- RESET_VALUE, 33'h0, value of config after reset.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- cfg_enable  input  1  frame enable; high for the whole frame.
- cfg_data  input  1  serial data, LSB first; valid at cfg_sclk rising edge.
- cfg_sclk  input  1  shift clock; data is sampled on its rising edge.
- config  output  WIDTH  committed configuration word.
- config_valid  output  1  one-cycle pulse when config is updated.
- busy  output  1  high while in RECV.
- frame_error  output  1  sticky error flag; cleared at the next frame start.
- bit_count  output  6  bits received in the current frame (0..WIDTH).

Behaviour:
- **Synchronizers:** cfg_enable, cfg_data and cfg_sclk each pass through SYNC_STAGES flops. The synced versions are en_s, d_s and sclk_s. Each input also has a one-flop delayed copy (en_p, sclk_p).
- **Edge detection:** sclk_rise = sclk_s & ~sclk_p. en_rise = en_s & ~en_p. en_fall = ~en_s & en_p.
- **Input timing:** each cfg_sclk level must be held ≥1 clk cycle. d_s is aligned with sclk_s because both use the same stage count.
- **State machine:**
  - IDLE: on en_rise go to RECV, clear bit_count and clear frame_error.
  - RECV:
    - en_fall → go to IDLE, set frame_error (short frame), leave config unchanged.
    - Otherwise, on sclk_rise: shreg <= {d_s, shreg[WIDTH-1:1]} and bit_count += 1.
    - When this edge captures bit WIDTH, go to DONE on the same edge. On that edge, config <= {d_s, shreg[WIDTH-1:1]} and config_valid = 1 for that cycle only.
  - DONE: further sclk_rise edges are ignored and set frame_error (overrun); config is kept. en_fall → IDLE. Enable may stay high indefinitely; the sequencer parks with enable high.
  - Illegal state → IDLE.
- **Latency:** config updates SYNC_STAGES+1 clk edges after the cfg_sclk rising edge that carries the last bit, counted from the first clk edge that samples cfg_sclk high.
- **Simultaneous events:**
  - sclk_rise in the same cycle as en_rise: ignored; the frame starts with the next edge.
  - sclk_rise in the same cycle as en_fall: ignored; short-frame handling applies.
- **Reset values:**
  - config = RESET_VALUE; config_valid, busy, frame_error = 0; bit_count = 0; state = IDLE.
  - Synchronizer flops = 0.
  - en_p = 1 and sclk_p = 1, so lines already high at reset release create no false edges. A new frame needs enable to be seen low, then high.
- **Reset mid-frame:** the partial frame is discarded, config returns to RESET_VALUE, and no config_valid pulse is issued.
- **Outputs:** bit_count saturates at WIDTH. busy = (state == RECV). shreg is not reset-critical; it is fully overwritten by every committed frame.

Test Plan:
1. Nominal frame: enable high, then 33 sclk pulses with 1-cycle high and low levels, carrying 33'h03C000000 LSB first → config = 33'h03C000000, one config_valid pulse, bit_count = 33, frame_error = 0, busy drops on the commit edge.
2. Short frame: config holds 33'h03C000000; send 20 bits of 33'h1FFFFFFFF, then drop enable → config unchanged, no config_valid pulse, frame_error = 1, state IDLE.
3. Overrun: after a full 33'h155555555 frame, send 3 extra pulses with enable still high → config = 33'h155555555, frame_error = 1, exactly one config_valid pulse.
4. Reset mid-frame: assert reset after 10 bits of a frame → config = 0, bit_count = 0, busy = 0. With enable held high after release, sclk pulses do nothing until enable goes low then high.
5. Back-to-back frames: 33'h0AAAAAAAA, enable low for 1 cycle, then 33'h0FFFF0000 → two config_valid pulses, final config = 33'h0FFFF0000, frame_error = 0.
6. Coincident edges: cfg_sclk and cfg_enable rise on the same clk edge, followed by 33 more pulses → first pulse ignored, frame commits the 33 following bits.
